// File: rtl/mul16_accumulator.sv
// mul16_accumulator: accumulates the 32-bit products of a LATENCY-deep
// pipelined 16x16 multiplier into an ACC_W-bit sum and returns each sum
// through a valid/ready handshake.
// Build option: define MUL16ACC_SAT_EN to clamp the accumulator on overflow
// (the default build wraps modulo 2^ACC_W). res_ovf is set in both builds.
// ACC_W must be at least 33 so that a sign-extended product always fits.

module mul16_accumulator #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned ACC_W   = 40,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic              issue_last,
   input  logic              issue_signed,
   input  logic [31:0]       product,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_ovf
);

   localparam int unsigned EXT_W = ACC_W - 32;

`ifdef MUL16ACC_SAT_EN
   localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   // Tag delay line, stage LATENCY-1 is the head.
   logic [LATENCY-1:0] vld_q, vld_d;
   logic [LATENCY-1:0] lst_q, lst_d;
   logic [LATENCY-1:0] sgn_q, sgn_d;

   // Running accumulation; cnt_q == 0 marks that the next beat is a first beat.
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;

   // Result holding registers.
   logic               res_valid_q, res_valid_d;
   logic [ACC_W-1:0]   res_data_q, res_data_d;
   logic [CNT_W-1:0]   res_count_q, res_count_d;
   logic               res_ovf_q, res_ovf_d;

   logic               last_in_flight_c;
   logic               accept_c;
   logic               head_vld_c, head_lst_c, head_sgn_c;
   logic [ACC_W-1:0]   ext_c;
   logic [ACC_W:0]     sum_c;
   logic               ovf_signed_c, ovf_beat_c;
   logic [ACC_W-1:0]   acc_nx_c;
   logic [CNT_W-1:0]   cnt_nx_c;
   logic               ovf_nx_c;

   // Issue backpressure: block while a last beat is in flight or a result is unread.
   always_comb begin
      last_in_flight_c = |(vld_q & lst_q);
      issue_ready      = rst_n && !last_in_flight_c && !(res_valid_q && !res_ready);
      accept_c         = issue_valid && issue_ready;
   end

   // Tag pipe advance; a non-accepted cycle enters a bubble.
   always_comb begin
      vld_d    = '0;
      lst_d    = '0;
      sgn_d    = '0;
      vld_d[0] = accept_c;
      lst_d[0] = accept_c & issue_last;
      sgn_d[0] = accept_c & issue_signed;
      for (int i = 1; i < int'(LATENCY); i++) begin
         vld_d[i] = vld_q[i-1];
         lst_d[i] = lst_q[i-1];
         sgn_d[i] = sgn_q[i-1];
      end
   end

   // Extend the head product, add it and flag overflow according to its signedness.
   always_comb begin
      head_vld_c   = vld_q[LATENCY-1];
      head_lst_c   = lst_q[LATENCY-1];
      head_sgn_c   = sgn_q[LATENCY-1];
      ext_c        = {{EXT_W{head_sgn_c & product[31]}}, product};
      sum_c        = {1'b0, acc_q} + {1'b0, ext_c};
      ovf_signed_c = (acc_q[ACC_W-1] == ext_c[ACC_W-1]) &&
                     (sum_c[ACC_W-1] != acc_q[ACC_W-1]);
      ovf_beat_c   = head_sgn_c ? ovf_signed_c : sum_c[ACC_W];

      acc_nx_c = acc_q;
      cnt_nx_c = cnt_q;
      ovf_nx_c = ovf_q;
      if (cnt_q == '0) begin
         acc_nx_c = ext_c;
         cnt_nx_c = CNT_W'(1);
         ovf_nx_c = 1'b0;
      end else begin
`ifdef MUL16ACC_SAT_EN
         if (ovf_beat_c) begin
            if (head_sgn_c) begin
               acc_nx_c = acc_q[ACC_W-1] ? SMIN : SMAX;
            end else begin
               acc_nx_c = '1;
            end
         end else begin
            acc_nx_c = sum_c[ACC_W-1:0];
         end
`else
         acc_nx_c = sum_c[ACC_W-1:0];
`endif
         cnt_nx_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
         ovf_nx_c = ovf_q | ovf_beat_c;
      end
   end

   // Next accumulator and result state; a landing last publishes the sum.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_count_d = res_count_q;
      res_ovf_d   = res_ovf_q;

      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      if (head_vld_c) begin
         acc_d = acc_nx_c;
         cnt_d = cnt_nx_c;
         ovf_d = ovf_nx_c;
         if (head_lst_c) begin
            cnt_d       = '0;
            res_valid_d = 1'b1;
            res_data_d  = acc_nx_c;
            res_count_d = cnt_nx_c;
            res_ovf_d   = ovf_nx_c;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q       <= '0;
         lst_q       <= '0;
         sgn_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_count_q <= '0;
         res_ovf_q   <= 1'b0;
      end else begin
         vld_q       <= vld_d;
         lst_q       <= lst_d;
         sgn_q       <= sgn_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_count_q <= res_count_d;
         res_ovf_q   <= res_ovf_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_count = res_count_q;
   assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_mul16_accumulator.sv
// Testbench for mul16_accumulator: a behavioural 4-stage multiplier feeds
// the product bus; directed vectors with hand-computed sums are checked.

module tb_mul16_accumulator;

   localparam int unsigned LATENCY = 4;
   localparam int unsigned ACC_W   = 40;
   localparam int unsigned CNT_W   = 16;

`ifdef MUL16ACC_SAT_EN
   localparam logic [39:0] OVF_EXP = 40'hFF_FFFF_FFFF;
`else
   localparam logic [39:0] OVF_EXP = 40'h00_FDFE_0101;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              issue_valid;
   logic              issue_ready;
   logic              issue_last;
   logic              issue_signed;
   logic [31:0]       product;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_data;
   logic [CNT_W-1:0]  res_count;
   logic              res_ovf;

   logic [15:0]       op_a;
   logic [15:0]       op_b;
   logic [31:0]       mp [LATENCY];

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sgn;
      logic [39:0] exp_data;
      logic [15:0] exp_count;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [8];

   mul16_accumulator #(
      .LATENCY (LATENCY),
      .ACC_W   (ACC_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_last   (issue_last),
      .issue_signed (issue_signed),
      .product      (product),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_count    (res_count),
      .res_ovf      (res_ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
      logic [31:0] xa;
      logic [31:0] xb;
      xa = s ? {{16{a[15]}}, a} : {16'h0000, a};
      xb = s ? {{16{b[15]}}, b} : {16'h0000, b};
      return 32'(xa * xb);
   endfunction

   // Multiplier model: runs every cycle, garbage when nothing is issued.
   always @(posedge clk) begin
      mp[0] <= issue_valid ? mul16(op_a, op_b, issue_signed) : 32'hDEAD_BEEF;
      for (int i = 1; i < int'(LATENCY); i++) begin
         mp[i] <= mp[i-1];
      end
   end
   assign product = mp[LATENCY-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and return just after the edge that accepts it.
   task automatic issue_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic s, input logic l);
      int n;
      op_a         = a;
      op_b         = b;
      issue_signed = s;
      issue_last   = l;
      issue_valid  = 1'b1;
      n = 0;
      while (!issue_ready && n < 50) begin
         step();
         n++;
      end
      if (!issue_ready) begin
         chk("issue_ready_timeout", 64'(issue_ready), 64'(1));
         issue_valid = 1'b0;
         return;
      end
      step();
   endtask

   // Wait for a result, compare it, then complete one handshake.
   task automatic wait_result(input string name, input logic [39:0] d,
                              input logic [15:0] c, input logic o);
      int n;
      n = 0;
      while (!res_valid && n < 50) begin
         step();
         n++;
      end
      chk({name, "_valid"}, 64'(res_valid), 64'(1));
      if (res_valid) begin
         chk({name, "_data"},  64'(res_data),  64'(d));
         chk({name, "_count"}, 64'(res_count), 64'(c));
         chk({name, "_ovf"},   64'(res_ovf),   64'(o));
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
         chk({name, "_cleared"}, 64'(res_valid), 64'(0));
      end
   endtask

   initial begin
      int seen;
      rst_n        = 1'b0;
      issue_valid  = 1'b0;
      issue_last   = 1'b0;
      issue_signed = 1'b0;
      res_ready    = 1'b0;
      op_a         = '0;
      op_b         = '0;

      vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b1, 40'h00_0000_0001, 16'd1, 1'b0};
      vecs[1] = '{16'h8000, 16'h0001, 1'b1, 40'hFF_FFFF_8000, 16'd1, 1'b0};
      vecs[2] = '{16'h8000, 16'h0001, 1'b0, 40'h00_0000_8000, 16'd1, 1'b0};
      vecs[3] = '{16'h8000, 16'h8000, 1'b1, 40'h00_4000_0000, 16'd1, 1'b0};
      vecs[4] = '{16'h1234, 16'h0010, 1'b0, 40'h00_0001_2340, 16'd1, 1'b0};
      vecs[5] = '{16'h7FFF, 16'h8000, 1'b1, 40'hFF_C000_8000, 16'd1, 1'b0};
      vecs[6] = '{16'h0000, 16'hABCD, 1'b0, 40'h00_0000_0000, 16'd1, 1'b0};
      vecs[7] = '{16'h8000, 16'h8000, 1'b0, 40'h00_4000_0000, 16'd1, 1'b0};

      // Reset state
      repeat (3) step();
      chk("rst_valid", 64'(res_valid),   64'(0));
      chk("rst_data",  64'(res_data),    64'(0));
      chk("rst_count", 64'(res_count),   64'(0));
      chk("rst_ovf",   64'(res_ovf),     64'(0));
      chk("rst_ready", 64'(issue_ready), 64'(0));
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", 64'(issue_ready), 64'(1));

      // Unsigned 0xFFFF*0xFFFF single beat with latency check
      issue_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      issue_valid = 1'b0;
      repeat (LATENCY - 1) step();
      chk("t1_not_early", 64'(res_valid), 64'(0));
      step();
      chk("t1_latency", 64'(res_valid), 64'(1));
      wait_result("t1", 40'h00_FFFE_0001, 16'd1, 1'b0);

      // Single-beat vector table
      for (int v = 0; v < 8; v++) begin
         issue_beat(vecs[v].a, vecs[v].b, vecs[v].sgn, 1'b1);
         issue_valid = 1'b0;
         wait_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_count,
                     vecs[v].exp_ovf);
      end

      // Signed 3 beats of -1
      issue_beat(16'hFFFF, 16'h0001, 1'b1, 1'b0);
      issue_beat(16'hFFFF, 16'h0001, 1'b1, 1'b0);
      issue_beat(16'hFFFF, 16'h0001, 1'b1, 1'b1);
      issue_valid = 1'b0;
      wait_result("signed3", 40'hFF_FFFF_FFFD, 16'd3, 1'b0);

      // Backpressure: result held 10 cycles while a new beat waits
      issue_beat(16'd2, 16'd3, 1'b0, 1'b1);
      issue_valid = 1'b0;
      repeat (LATENCY) step();
      chk("bp_valid", 64'(res_valid), 64'(1));
      op_a         = 16'd7;
      op_b         = 16'd7;
      issue_signed = 1'b0;
      issue_last   = 1'b1;
      issue_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp_data_c%0d", i),  64'(res_data),    64'(6));
         chk($sformatf("bp_count_c%0d", i), 64'(res_count),   64'(1));
         chk($sformatf("bp_ready_c%0d", i), 64'(issue_ready), 64'(0));
         step();
      end
      res_ready = 1'b1;
      #1;
      chk("bp_ready_same_cycle", 64'(issue_ready), 64'(1));
      @(posedge clk);
      #1;
      res_ready   = 1'b0;
      issue_valid = 1'b0;
      chk("bp_handshake_clear", 64'(res_valid), 64'(0));
      wait_result("bp_next", 40'd49, 16'd1, 1'b0);

      // 257 unsigned max products, back to back
      for (int i = 0; i < 257; i++) begin
         issue_beat(16'hFFFF, 16'hFFFF, 1'b0, (i == 256));
      end
      issue_valid = 1'b0;
      wait_result("ovf257", OVF_EXP, 16'd257, 1'b1);

      // Reset in the middle of an accumulation
      issue_beat(16'd9, 16'd9, 1'b0, 1'b0);
      issue_beat(16'd9, 16'd9, 1'b0, 1'b1);
      issue_valid = 1'b0;
      rst_n       = 1'b0;
      #1;
      chk("midrst_ready_low", 64'(issue_ready), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_data", 64'(res_data),  64'(0));
      chk("midrst_ovf",  64'(res_ovf),   64'(0));
      seen = 0;
      repeat (8) begin
         if (res_valid) seen++;
         step();
      end
      chk("midrst_no_result", 64'(seen), 64'(0));
      issue_beat(16'd3, 16'd5, 1'b0, 1'b1);
      issue_valid = 1'b0;
      wait_result("midrst_next", 40'd15, 16'd1, 1'b0);

      // Bubbles between beats
      issue_beat(16'd2, 16'd2, 1'b0, 1'b0);
      issue_valid = 1'b0;
      repeat (3) step();
      issue_beat(16'd4, 16'd4, 1'b0, 1'b1);
      issue_valid = 1'b0;
      repeat (LATENCY - 1) step();
      chk("bub_not_early", 64'(res_valid), 64'(0));
      step();
      chk("bub_latency", 64'(res_valid), 64'(1));
      wait_result("bub", 40'd20, 16'd2, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d",
               pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule

// File: doc/mul16_accumulator.md
# mul16_accumulator

Accumulation stage directly downstream of the 4-stage pipelined radix-4 Booth/Wallace 16x16 multiplier. It consumes the multiplier's 32-bit `out` bus and tracks beat validity in a tag pipeline matched to the multiplier latency. It sign- or zero-extends each product and sums the products into a wide accumulator. It then presents the final sum of each accumulation through a valid/ready result handshake, with backpressure on issue.

## Interface
- `LATENCY`, 4: multiplier pipeline depth in cycles (tag delay line length).
- `ACC_W`, 40: accumulator/result width; must be ≥ 33.
- `CNT_W`, 16: beat-counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `issue_valid` in 1: upstream presents operands to the multiplier this cycle.
- `issue_ready` out 1: beat accepted when `issue_valid && issue_ready`.
- `issue_last` in 1: tag; accepted beat closes the current accumulation.
- `issue_signed` in 1: tag; beat's product is signed (mirrors multiplier `signedFlag`).
- `product` in 32: multiplier `out`.
- `res_valid` out 1: final sum available.
- `res_ready` in 1: consumer accepts result.
- `res_data` out ACC_W: accumulated sum.
- `res_count` out CNT_W: number of beats in the accumulation.
- `res_ovf` out 1: overflow/saturation occurred during the accumulation (sticky).

## Operation
- Tag pipe: LATENCY stages of {valid, last, signed}. An accepted beat enters stage 0. Non-accepted cycles insert a bubble (valid=0).
- At the tag-pipe head with valid=1, `product` is extended to ACC_W:
  - sign-extended if the signed tag is 1, zero-extended otherwise;
  - it is then added to `acc`.
- First beat of an accumulation: `acc` loads the extended product, the count goes to 1, and ovf clears. A beat is first after reset or after a last beat.
- Overflow detection follows each beat's signed tag.
  - Signed: the two's-complement add overflows.
  - Unsigned: carry out of bit ACC_W-1.
- Beat counter increments per beat and saturates at all-ones.
- Head beat with last=1: `res_data`/`res_count`/`res_ovf` load the final values and `res_valid` sets.
- `res_valid` clears on `res_valid && res_ready`. Result outputs stay stable while `res_valid && !res_ready`.
- `issue_ready = rst_n && !last_in_flight && !(res_valid && !res_ready)`.
  - `last_in_flight` = any tag stage holds valid&last.
  - This guarantees at most one result pending; a landing last never overwrites an unread result.
- Upstream keeps multiplier `signedFlag` equal to `issue_signed` for each accepted beat. Product bits arriving with valid tag 0 are ignored.
- Reset: all tag stages cleared; `acc`, count and ovf cleared. Outputs `res_valid=0`, `res_data=0`, `res_count=0`, `res_ovf=0`, `issue_ready=0` while `rst_n=0`.
- Reset mid-accumulation discards in-flight beats and the partial sum. Products still exiting the multiplier are ignored.

## Timing
- Beat accepted at edge k → its product is sampled at edge k+LATENCY.
- If that beat is last, `res_valid`=1 after edge k+LATENCY.
- Full throughput: one beat per cycle, bubbles allowed anywhere.
- After a last beat is accepted, `issue_ready`=0 until that beat lands. It then stays 0 until the result handshake, and rises combinationally in the handshake cycle.
- Same-cycle handshake and new first beat landing: cannot collide, by the `issue_ready` rule.

## Configuration
- `MUL16ACC_SAT_EN` defined: on overflow the accumulator clamps and `res_ovf` is set.
  - Signed beat: clamp to the signed ACC_W max/min.
  - Unsigned beat: clamp to all-ones.
- `MUL16ACC_SAT_EN` undefined: modular wrap at ACC_W bits; `res_ovf` is still set on overflow.

## Test plan
- Unsigned single beat 0xFFFF×0xFFFF, last, accepted at edge 0 → after edge 4 `res_valid`=1, `res_data`=0x00FFFE0001, `res_count`=1, `res_ovf`=0.
- Signed 3 beats of 0xFFFF×0x0001 (product 0xFFFFFFFF), last on the 3rd → `res_data`=0xFFFFFFFFFD, `res_count`=3, `res_ovf`=0.
- Backpressure: hold `res_ready`=0 for 10 cycles after `res_valid` → `res_data`/`res_count` stable, `issue_ready`=0 throughout; release → one handshake, `issue_ready`=1 the same cycle.
- Overflow: 257 unsigned beats of 0xFFFF×0xFFFF → wrap build gives `res_data`=0x00FDFE0101 and `res_ovf`=1; with `MUL16ACC_SAT_EN`, `res_data`=0xFFFFFFFFFF and `res_ovf`=1.
- Reset mid-op: accept 2 beats, pull `rst_n` low for 1 cycle at edge 2 → no `res_valid` from those beats; next single beat 3×5, last → `res_data`=15, `res_count`=1.
- Bubbles: beats 2×2, gap of 3 cycles, 4×4, last → `res_data`=20, `res_count`=2, `res_valid` 4 cycles after the last issue edge.
